// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: FSM state encoding, BCD digit
// limits and the 7-segment glyph table ({g,f,e,d,c,b,a}, active-high).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Non-BCD codes blank the display rather than showing a misleading glyph.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_seg7.sv
// Single-digit BCD to 7-segment decoder, polarity selectable per board.
module seg7_decoder
  import stopwatch_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = bcd_to_seg(bcd);
  end

  assign seg = ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.t stopwatch: button synchronisers, run/pause controller and a BCD
// counter chain advanced by the 100 ms tick, driving five 7-segment digits.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_startstop,
  input  logic       btn_clear,
  output logic       running,
  output logic       wrap,
  output logic [3:0] d_tenths,
  output logic [3:0] d_sec_u,
  output logic [3:0] d_sec_t,
  output logic [3:0] d_min_u,
  output logic [3:0] d_min_t,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4
);

  // Bit 0 carries start/stop, bit 1 carries clear.
  logic [1:0] btn_s0, btn_s1, btn_s2;
  logic       ss_press, clr_press;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      btn_s0 <= 2'b00;
      btn_s1 <= 2'b00;
      btn_s2 <= 2'b00;
    end else begin
      btn_s0 <= {btn_clear, btn_startstop};
      btn_s1 <= btn_s0;
      btn_s2 <= btn_s1;
    end
  end

  assign ss_press  = btn_s1[0] & ~btn_s2[0];
  assign clr_press = btn_s1[1] & ~btn_s2[1];

  state_t state;
  logic   count_en;
  logic   c0, c1, c2, c3, c4;

  // Tick qualifies against the registered state, so a press that leaves
  // RUNNING still counts its coincident tick and one that enters does not.
  assign count_en = tick & (state == RUNNING);
  assign c0 = (d_tenths == BCD_MAX9);
  assign c1 = c0 & (d_sec_u == BCD_MAX9);
  assign c2 = c1 & (d_sec_t == BCD_MAX5);
  assign c3 = c2 & (d_min_u == BCD_MAX9);
  assign c4 = c3 & (d_min_t == BCD_MAX5);

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      running  <= 1'b0;
      wrap     <= 1'b0;
      d_tenths <= 4'd0;
      d_sec_u  <= 4'd0;
      d_sec_t  <= 4'd0;
      d_min_u  <= 4'd0;
      d_min_t  <= 4'd0;
    end else if (clr_press) begin
      state    <= IDLE;
      running  <= 1'b0;
      wrap     <= 1'b0;
      d_tenths <= 4'd0;
      d_sec_u  <= 4'd0;
      d_sec_t  <= 4'd0;
      d_min_u  <= 4'd0;
      d_min_t  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_press) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
        end
        RUNNING: begin
          if (ss_press) begin
            state   <= PAUSED;
            running <= 1'b0;
          end
        end
        PAUSED: begin
          if (ss_press) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      wrap <= count_en & c4;

      if (count_en) begin
        d_tenths <= c0 ? 4'd0 : d_tenths + 4'd1;
        if (c0) d_sec_u <= c1 ? 4'd0 : d_sec_u + 4'd1;
        if (c1) d_sec_t <= c2 ? 4'd0 : d_sec_t + 4'd1;
        if (c2) d_min_u <= c3 ? 4'd0 : d_min_u + 4'd1;
        if (c3) d_min_t <= c4 ? 4'd0 : d_min_t + 4'd1;
      end
    end
  end

  seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg0 (.bcd(d_tenths), .seg(hex0));
  seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg1 (.bcd(d_sec_u),  .seg(hex1));
  seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg2 (.bcd(d_sec_t),  .seg(hex2));
  seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg3 (.bcd(d_min_u),  .seg(hex3));
  seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg4 (.bcd(d_min_t),  .seg(hex4));

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: reset, run/pause, carries, wrap,
// coincident button/tick events and a held button.
module tb_stopwatch_bcd;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_startstop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       running, wrap;
  logic [3:0] d_tenths, d_sec_u, d_sec_t, d_min_u, d_min_t;
  logic [6:0] hex0, hex1, hex2, hex3, hex4;
  logic [19:0] digits;

  int n_cmp = 0;
  int n_fail = 0;

  // Active-low glyphs for the digits the bench looks at.
  localparam logic [6:0] HEX_0 = 7'b1000000;
  localparam logic [6:0] HEX_2 = 7'b0100100;
  localparam logic [6:0] HEX_5 = 7'b0010010;

  stopwatch_bcd #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clkin(clkin), .rst(rst), .tick(tick),
    .btn_startstop(btn_startstop), .btn_clear(btn_clear),
    .running(running), .wrap(wrap),
    .d_tenths(d_tenths), .d_sec_u(d_sec_u), .d_sec_t(d_sec_t),
    .d_min_u(d_min_u), .d_min_t(d_min_t),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4)
  );

  assign digits = {d_min_t, d_min_u, d_sec_t, d_sec_u, d_tenths};

  always #5 clkin = ~clkin;

  task automatic press_ss();
    btn_startstop = 1'b1;
    repeat (3) @(negedge clkin);
    btn_startstop = 1'b0;
    repeat (3) @(negedge clkin);
  endtask

  task automatic press_clr();
    btn_clear = 1'b1;
    repeat (3) @(negedge clkin);
    btn_clear = 1'b0;
    repeat (3) @(negedge clkin);
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clkin);
    tick = 1'b0;
  endtask

  // Buttons rise, and tick lands on the edge where the press is registered.
  task automatic press_with_tick(input logic clr, input logic ss);
    btn_clear = clr;
    btn_startstop = ss;
    repeat (2) @(negedge clkin);
    tick = 1'b1;
    @(negedge clkin);
    tick = 1'b0;
  endtask

  task automatic release_buttons();
    btn_clear = 1'b0;
    btn_startstop = 1'b0;
    repeat (3) @(negedge clkin);
  endtask

  task automatic test_reset();
    n_cmp++; if (digits !== 20'h00000 || running !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: digits=%h running=%b wrap=%b, need 00000/0/0", digits, running, wrap);
    end
    n_cmp++; if (hex0 !== HEX_0 || hex4 !== HEX_0) begin
      n_fail++; $display("FAIL reset_hex: hex0=%b hex4=%b, need %b", hex0, hex4, HEX_0);
    end
    press_ss();
    run_ticks(7545);
    n_cmp++; if (digits !== 20'h12345 || running !== 1'b1) begin
      n_fail++; $display("FAIL count_12345: digits=%h running=%b, need 12345/1", digits, running);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (digits !== 20'h00000 || running !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: digits=%h running=%b wrap=%b, need 00000/0/0", digits, running, wrap);
    end
    n_cmp++; if (hex0 !== HEX_0 || hex3 !== HEX_0) begin
      n_fail++; $display("FAIL async_reset_hex: hex0=%b hex3=%b, need %b", hex0, hex3, HEX_0);
    end
    @(negedge clkin);
    rst = 1'b0;
    @(negedge clkin);
  endtask

  task automatic test_start_count();
    press_ss();
    run_ticks(25);
    n_cmp++; if (digits !== 20'h00025 || running !== 1'b1) begin
      n_fail++; $display("FAIL start_count: digits=%h running=%b, need 00025/1", digits, running);
    end
    n_cmp++; if (hex0 !== HEX_5 || hex1 !== HEX_2 || hex2 !== HEX_0) begin
      n_fail++; $display("FAIL start_hex: hex0=%b hex1=%b hex2=%b, need %b %b %b", hex0, hex1, hex2, HEX_5, HEX_2, HEX_0);
    end
    press_ss();
    run_ticks(10);
    n_cmp++; if (digits !== 20'h00025 || running !== 1'b0) begin
      n_fail++; $display("FAIL pause_hold: digits=%h running=%b, need 00025/0", digits, running);
    end
    press_ss();
    run_ticks(5);
    n_cmp++; if (digits !== 20'h00030 || running !== 1'b1) begin
      n_fail++; $display("FAIL resume_count: digits=%h running=%b, need 00030/1", digits, running);
    end
    press_clr();
    n_cmp++; if (digits !== 20'h00000 || running !== 1'b0) begin
      n_fail++; $display("FAIL clear: digits=%h running=%b, need 00000/0", digits, running);
    end
    run_ticks(3);
    n_cmp++; if (digits !== 20'h00000) begin
      n_fail++; $display("FAIL idle_ignores_tick: digits=%h, need 00000", digits);
    end
  endtask

  task automatic test_carry_and_wrap();
    press_ss();
    run_ticks(99);
    n_cmp++; if (digits !== 20'h00099) begin
      n_fail++; $display("FAIL carry_pre_00099: digits=%h, need 00099", digits);
    end
    run_ticks(1);
    n_cmp++; if (digits !== 20'h00100) begin
      n_fail++; $display("FAIL carry_00100: digits=%h, need 00100", digits);
    end
    run_ticks(5899);
    n_cmp++; if (digits !== 20'h09599) begin
      n_fail++; $display("FAIL carry_pre_09599: digits=%h, need 09599", digits);
    end
    run_ticks(1);
    n_cmp++; if (digits !== 20'h10000) begin
      n_fail++; $display("FAIL carry_10000: digits=%h, need 10000", digits);
    end
    run_ticks(29998);
    n_cmp++; if (digits !== 20'h59598 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL wrap_pre: digits=%h wrap=%b, need 59598/0", digits, wrap);
    end
    run_ticks(1);
    n_cmp++; if (digits !== 20'h59599 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL wrap_59599: digits=%h wrap=%b, need 59599/0", digits, wrap);
    end
    run_ticks(1);
    n_cmp++; if (digits !== 20'h00000 || wrap !== 1'b1 || running !== 1'b1) begin
      n_fail++; $display("FAIL wrap_rollover: digits=%h wrap=%b running=%b, need 00000/1/1", digits, wrap, running);
    end
    @(negedge clkin);
    n_cmp++; if (wrap !== 1'b0) begin
      n_fail++; $display("FAIL wrap_one_cycle: wrap=%b, need 0", wrap);
    end
    run_ticks(1);
    n_cmp++; if (digits !== 20'h00001 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL after_wrap: digits=%h wrap=%b, need 00001/0", digits, wrap);
    end
  endtask

  task automatic test_simultaneous();
    press_clr();
    press_ss();
    run_ticks(9);
    press_with_tick(1'b1, 1'b0);
    n_cmp++; if (digits !== 20'h00000 || running !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL clear_vs_tick: digits=%h running=%b wrap=%b, need 00000/0/0", digits, running, wrap);
    end
    release_buttons();
    run_ticks(2);
    n_cmp++; if (digits !== 20'h00000) begin
      n_fail++; $display("FAIL clear_vs_tick_idle: digits=%h, need 00000", digits);
    end
    press_ss();
    run_ticks(10);
    press_with_tick(1'b0, 1'b1);
    n_cmp++; if (digits !== 20'h00011 || running !== 1'b0) begin
      n_fail++; $display("FAIL stop_vs_tick: digits=%h running=%b, need 00011/0", digits, running);
    end
    release_buttons();
    run_ticks(2);
    n_cmp++; if (digits !== 20'h00011) begin
      n_fail++; $display("FAIL stop_vs_tick_paused: digits=%h, need 00011", digits);
    end
    btn_clear = 1'b1;
    btn_startstop = 1'b1;
    repeat (3) @(negedge clkin);
    release_buttons();
    run_ticks(2);
    n_cmp++; if (digits !== 20'h00000 || running !== 1'b0) begin
      n_fail++; $display("FAIL clear_vs_start: digits=%h running=%b, need 00000/0", digits, running);
    end
    press_with_tick(1'b0, 1'b1);
    n_cmp++; if (digits !== 20'h00000 || running !== 1'b1) begin
      n_fail++; $display("FAIL start_vs_tick: digits=%h running=%b, need 00000/1", digits, running);
    end
    release_buttons();
    run_ticks(1);
    n_cmp++; if (digits !== 20'h00001) begin
      n_fail++; $display("FAIL start_vs_tick_next: digits=%h, need 00001", digits);
    end
  endtask

  task automatic test_held_button();
    press_clr();
    btn_startstop = 1'b1;
    repeat (3) @(negedge clkin);
    n_cmp++; if (running !== 1'b1) begin
      n_fail++; $display("FAIL held_start: running=%b, need 1", running);
    end
    for (int i = 0; i < 99; i++) begin
      tick = 1'b1;
      @(negedge clkin);
      tick = 1'b0;
      repeat (9) @(negedge clkin);
    end
    repeat (7) @(negedge clkin);
    n_cmp++; if (digits !== 20'h00099 || running !== 1'b1) begin
      n_fail++; $display("FAIL held_count: digits=%h running=%b, need 00099/1", digits, running);
    end
    btn_startstop = 1'b0;
    repeat (4) @(negedge clkin);
    n_cmp++; if (running !== 1'b1) begin
      n_fail++; $display("FAIL held_release: running=%b, need 1", running);
    end
  endtask

  initial begin
    repeat (3) @(negedge clkin);
    rst = 1'b0;
    @(negedge clkin);
    test_reset();
    test_start_count();
    test_carry_and_wrap();
    test_simultaneous();
    test_held_button();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
